// File: rtl/register_bank_mp.sv
// Two-write-port register bank with a combinational multi-port read path and
// a full-bank clear sweep that also runs out of reset.
//
// state | meaning
// IDLE  | normal operation, writes commit, reads may bypass write data
// CLEAR | sweeping bank[cnt] to zero, writes dropped, reads return zero
module register_bank_mp #(
  parameter int DATA_WIDTH  = 32,
  parameter int WORDS       = 32,
  parameter int SELECT_SIZE = 5,
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          we_a_ni,
  input  logic [SELECT_SIZE-1:0]        dst_a_i,
  input  logic [DATA_WIDTH-1:0]         data_a_i,
  input  logic                          we_b_ni,
  input  logic [SELECT_SIZE-1:0]        dst_b_i,
  input  logic [DATA_WIDTH-1:0]         data_b_i,
  input  logic [NUM_RD*SELECT_SIZE-1:0] rd_sel_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data_o,
  input  logic                          clear_i,
  output logic                          busy_o,
  output logic                          collide_o,
  output logic                          drop_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [SELECT_SIZE-1:0] LAST = SELECT_SIZE'(WORDS - 1);

  state_t                  state_q, state_d;
  logic [SELECT_SIZE-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   bank [WORDS];
  logic                    wr_a, wr_b;
  logic                    collide_d, drop_d;
  logic [SELECT_SIZE-1:0]  sel;
  logic [DATA_WIDTH-1:0]   val;

  function automatic logic is_zero(input logic [SELECT_SIZE-1:0] dst);
    return (ZERO_REG != 0) && (dst == '0);
  endfunction

  always_comb begin
    wr_a      = !we_a_ni && (state_q == IDLE) && !is_zero(dst_a_i);
    wr_b      = !we_b_ni && (state_q == IDLE) && !is_zero(dst_b_i);
    collide_d = (state_q == IDLE) && !we_a_ni && !we_b_ni &&
                (dst_a_i == dst_b_i) && !is_zero(dst_a_i);
    drop_d    = (state_q == CLEAR) && (!we_a_ni || !we_b_ni);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + SELECT_SIZE'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      collide_o <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      collide_o <= collide_d;
      drop_o    <= drop_d;
    end
  end

  // Bank has no reset of its own; the sweep is the only way to zero it.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state_q == CLEAR) begin
        bank[cnt_q] <= '0;
      end else begin
        if (wr_a && !(wr_b && (dst_b_i == dst_a_i))) bank[dst_a_i] <= data_a_i;
        if (wr_b) bank[dst_b_i] <= data_b_i;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    sel       = '0;
    val       = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      sel = rd_sel_i[k*SELECT_SIZE +: SELECT_SIZE];
      val = bank[sel];
      if (BYPASS != 0) begin
        if (wr_a && (dst_a_i == sel)) val = data_a_i;
        if (wr_b && (dst_b_i == sel)) val = data_b_i;
      end
      if (is_zero(sel) || (state_q == CLEAR)) val = '0;
      rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = val;
    end
  end

  assign busy_o = (state_q == CLEAR);

endmodule

// File: doc/register_bank_mp.md
REGISTER_BANK_MP -- requirements
Module: register_bank_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: register width in bits.
REQ-002 The block SHALL have parameter WORDS, default 32: number of registers, at least 2.
REQ-003 The block SHALL have parameter SELECT_SIZE, default 5: select width, with 2**SELECT_SIZE == WORDS.
REQ-004 The block SHALL have parameter NUM_RD, default 2: number of read ports, 1 to 4.
REQ-005 The block SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-006 The block SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the reads.
REQ-007 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-009 The block SHALL have port we_a_ni, input, 1 bit: write port A enable, active low.
REQ-010 The block SHALL have port dst_a_i, input, SELECT_SIZE bits: port A destination.
REQ-011 The block SHALL have port data_a_i, input, DATA_WIDTH bits: port A write data.
REQ-012 The block SHALL have ports we_b_ni, dst_b_i and data_b_i, identical to REQ-009..011 for write port B.
REQ-013 The block SHALL have port rd_sel_i, input, NUM_RD*SELECT_SIZE bits: read selects; port k uses slice k.
REQ-014 The block SHALL have port rd_data_o, output, NUM_RD*DATA_WIDTH bits: read data; port k uses slice k.
REQ-015 The block SHALL have port clear_i, input, 1 bit: request a full-bank clear sweep.
REQ-016 The block SHALL have port busy_o, output, 1 bit: high while a clear sweep is active.
REQ-017 The block SHALL have port collide_o, output, 1 bit: one-cycle pulse on a same-destination dual write.
REQ-018 The block SHALL have port drop_o, output, 1 bit: one-cycle pulse when a write is discarded because busy_o was high.

Function
REQ-019 The block SHALL have exactly two FSM states, IDLE and CLEAR, with a clear counter cnt of width SELECT_SIZE.
REQ-020 In IDLE with clear_i=1, the FSM SHALL go to CLEAR with cnt=0 at the next edge; busy_o SHALL be high from that cycle onward.
REQ-021 In CLEAR, each edge SHALL write bank[cnt]=0 and increment cnt; when cnt==WORDS-1 the FSM SHALL go to IDLE, making a sweep exactly WORDS cycles.
REQ-022 clear_i asserted during CLEAR SHALL be ignored, with no restart and no extension of the sweep.
REQ-023 busy_o SHALL be 1 exactly when the state is CLEAR.
REQ-024 In IDLE, an enabled write SHALL update bank[dst] at the clock edge.
REQ-025 When ZERO_REG=1, writes to dst 0 SHALL be discarded and reads of select 0 SHALL return 0.
REQ-026 When both ports write the same destination in one cycle, port B SHALL win, and collide_o SHALL be 1 in the following cycle unless the destination is 0 with ZERO_REG=1.
REQ-027 Writes by both ports to different destinations in the same cycle SHALL both commit.
REQ-028 In CLEAR, all writes SHALL be discarded, and drop_o SHALL pulse in the next cycle if either enable was active.
REQ-029 Reads SHALL be combinational: rd_data_o[k] = bank[rd_sel_i[k]], with zero latency.
REQ-030 When BYPASS=1 and in IDLE, a read matching an active write destination SHALL return that cycle's write data, with B taking priority over A and the ZERO_REG rule taking precedence.
REQ-031 When BYPASS=0, reads SHALL return pre-edge contents.
REQ-032 In CLEAR, every rd_data_o slice SHALL read 0.
REQ-033 collide_o and drop_o SHALL be registered pulses that are never high for two consecutive cycles unless the triggering event repeats.

Reset
REQ-034 While rst_ni=0 at an edge, the block SHALL set state=CLEAR, cnt=0, collide_o=0 and drop_o=0, so busy_o=1 and rd_data_o=0.
REQ-035 After rst_ni rises, the block SHALL complete a full WORDS-cycle sweep, so all registers read 0 before busy_o falls.
REQ-036 Reset asserted mid-sweep SHALL restart the sweep at cnt=0.
REQ-037 Bank contents SHALL have no reset other than through the sweep.

Verification
REQ-038 The bench SHALL hold reset 2 cycles then release it, and SHALL see busy_o high for exactly 32 cycles, then low, with all 32 registers reading 0.
REQ-039 The bench SHALL write A: x5=0xDEADBEEF and B: x7=0x12345678 in one cycle, and SHALL then read x5 and x7 on both ports and get the written values, with collide_o=0.
REQ-040 The bench SHALL write A: x9=0x1 and B: x9=0x2 in one cycle, and SHALL see x9 read 0x2 and collide_o pulse for 1 cycle.
REQ-041 With BYPASS=1, the bench SHALL write x3=0xAA while reading x3, and SHALL see 0xAA in the same cycle; the bench SHALL also write x0=0xFF and see x0 read 0 and collide_o stay 0.
REQ-042 The bench SHALL pulse clear_i, write x4 during the sweep, and SHALL see drop_o pulse and x4 read 0 after busy_o falls.
REQ-043 The bench SHALL assert reset at sweep cycle 10 and release it, and SHALL see busy_o stay high for 32 further cycles.
